fir_out_requant: RTL and testbench
==================================

Name: fir_out_requant

Overview:
- Output back-end placed directly downstream of the 20-tap DA FIR filter (FIR20).
- Consumes the filter's 30-bit signed full-precision result on every clock.
- Rounds, shifts and saturates it to a narrow sample, decimates by an integer factor, and buffers results in a small FIFO.
- Drains the FIFO through a valid/ready interface to the next consumer, typically a DAC or packetiser.

Parameters:
- DIN_W, 30, input width; matches the FIR filter_out width.
- OUT_W, 16, output sample width, signed.
- SHIFT, 14, right-shift applied after rounding; must satisfy 1 ≤ SHIFT < DIN_W.
- DEC, 4, decimation factor; 1 means no decimation.
- PHASE, 0, which decimation phase is kept; 0 ≤ PHASE < DEC.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.

Ports:
- clk, in, 1: single clock, all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- din, in, DIN_W: signed FIR output sample.
- din_vld, in, 1: din qualifies this cycle; tied high when the FIR runs free.
- clr, in, 1: synchronous clear of the sticky flags only.
- dout, out, OUT_W: signed sample at the FIFO head.
- dout_vld, out, 1: FIFO not empty.
- dout_rdy, in, 1: consumer accepts dout.
- level, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- sat_sticky, out, 1: set when any kept sample saturated.
- drop_sticky, out, 1: set when any kept sample was lost because the FIFO was full.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers cleared; dec counter = 0; FIFO empty.
  - dout_vld=0, dout=0, level=0, sat_sticky=0, drop_sticky=0.
  - Reset asserted mid-operation discards all buffered samples and pipeline contents immediately.
- Decimation counter:
  - Counts 0..DEC-1 and advances only on din_vld=1, wrapping DEC-1 → 0.
  - A sample is "kept" when din_vld=1 and the count equals PHASE.
  - The first din_vld cycle after reset has count 0.
- Stage 1, registered, kept samples only:
  - r = (din + 2^(SHIFT-1)) >>> SHIFT, computed in DIN_W+1 bits so the add cannot overflow.
  - Arithmetic shift gives round-half-up: +3.5 → 4, -3.5 → -3.
- Stage 2, registered:
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Any clipping sets sat_sticky.
- FIFO push:
  - Occurs on the cycle after stage 2. Latency from a kept din to FIFO write is 2 clocks; dout_vld rises on the 3rd edge when the FIFO was empty.
  - No fall-through bypass.
- FIFO pop: occurs when dout_vld && dout_rdy; the head advances at the edge.
- dout is registered and holds stable while dout_vld=1 and dout_rdy=0.
- Push while full with no pop: the sample is dropped, FIFO contents are unchanged, drop_sticky is set.
- Push while full with a simultaneous pop: push succeeds and level stays at FIFO_DEPTH.
- Push and pop on the same cycle at any other level: level unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full is level == FIFO_DEPTH; empty is level == 0.
- din_vld=0 stalls the decimation counter but does not stall stages already in flight; the pipeline is not back-pressured.
- Sticky flags:
  - clr=1 clears both flags at the edge.
  - If a set event occurs in the same cycle as clr, set wins.
- Rounding/saturation are arithmetic only; no dither.

Decomposition:
- Package fir_pkg holds:
  - FIR_DOUT_W = 30, matching the filter output width.
  - Default OUT_W, SHIFT and DEC constants.
  - A function sat_signed(value, width) used by stage 2.
- One sub-module, fir_sync_fifo (parameters W, DEPTH):
  - Registered head output and level count.
  - Push/pop/full/empty logic.
  - The top level owns the counter, round/sat pipeline and sticky flags.

Test Plan:
- Rounding: DEC=1, dout_rdy=1.
  - din=122880 → dout=8, 3 edges later.
  - din=-122880 → dout=-7.
  - din=8191 → 0; din=8192 → 1.
  - sat_sticky stays 0.
- Saturation: DEC=1.
  - din=536862720 → dout=32767, sat_sticky=1.
  - din=-536870912 → dout=-32768 with no new saturation; clr=1 then reads sat_sticky=0.
- Decimation: DEC=4, PHASE=0, din_vld=1 continuous, din=k*16384 for k=0,1,2,...
  - Output sequence is 0,4,8,12.
  - With PHASE=3 the sequence is 3,7,11.
  - Deasserting din_vld for 5 cycles does not change the sequence.
- Overflow: DEC=1, dout_rdy=0, push values 1..5.
  - level=4 and drop_sticky=1; value 5 is lost.
  - Raising dout_rdy drains 1,2,3,4 in order, then dout_vld=0.
- Full with simultaneous push/pop: fill to 4, then on the cycle a 5th sample arrives hold dout_rdy=1.
  - level stays 4 and drop_sticky stays 0.
  - Drain order is correct.
- Reset mid-operation: with level=3 and samples in the pipeline, pulse rst_n low for 1 cycle.
  - dout_vld=0, level=0, both flags 0 immediately (asynchronously).
  - The next kept sample is counted from phase 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and the saturation helper for the FIR output back-end.
package fir_pkg;

   localparam int FIR_DOUT_W = 30;
   localparam int DEF_OUT_W  = 16;
   localparam int DEF_SHIFT  = 14;
   localparam int DEF_DEC    = 4;

   // Clamp a value to the signed range representable in 'width' bits.
   function automatic logic signed [FIR_DOUT_W:0] sat_signed(
      input logic signed [FIR_DOUT_W:0] value,
      input int                         width
   );
      logic signed [FIR_DOUT_W:0] one;
      logic signed [FIR_DOUT_W:0] hi;
      logic signed [FIR_DOUT_W:0] lo;
      one    = '0;
      one[0] = 1'b1;
      hi     = (one <<< (width - 1)) - one;
      lo     = -hi - one;
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Small synchronous FIFO with a registered head word and occupancy count.
module fir_sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE_LVL  = (AW + 1)'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_next;
   logic          full;
   logic          do_pop;
   logic          do_push;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;
   assign rd_next = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_next;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         // The head register is refilled from memory or directly from the write data
         // when the incoming word becomes the new head.
         if (do_push && (empty || (do_pop && level == ONE_LVL))) begin
            head <= wdata;
         end else if (do_pop && level > ONE_LVL) begin
            head <= mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output back-end: decimate, round, shift, saturate and buffer samples
// behind a valid/ready port (dout_vld = FIFO not empty; transfer when dout_vld && dout_rdy).
module fir_out_requant
   import fir_pkg::*;
#(
   parameter int DIN_W      = FIR_DOUT_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int SHIFT      = DEF_SHIFT,
   parameter int DEC        = DEF_DEC,
   parameter int PHASE      = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [DIN_W-1:0]     din,
   input  logic                        din_vld,
   input  logic                        clr,
   output logic signed [OUT_W-1:0]     dout,
   output logic                        dout_vld,
   input  logic                        dout_rdy,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        sat_sticky,
   output logic                        drop_sticky
);

   localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
   localparam int RW = DIN_W + 1;
   localparam logic [CW-1:0]        LAST    = CW'(DEC - 1);
   localparam logic [CW-1:0]        KEEP_PH = CW'(PHASE);
   localparam logic signed [RW-1:0] RND     = RW'(1) <<< (SHIFT - 1);

   logic [CW-1:0]        cnt;
   logic                 keep;
   logic signed [RW-1:0] sum;
   logic signed [RW-1:0] r;
   logic signed [RW-1:0] s1_r;
   logic signed [RW-1:0] sat_v;
   logic                 s1_vld;
   logic                 s2_vld;
   logic [OUT_W-1:0]     s2_data;
   logic                 clip;
   logic                 fifo_empty;
   logic                 fifo_drop;
   logic [OUT_W-1:0]     fifo_head;

   assign keep  = din_vld && (cnt == KEEP_PH);
   // One guard bit keeps the rounding add from overflowing; the arithmetic shift
   // then rounds half towards +infinity.
   assign sum   = RW'(din) + RND;
   assign r     = sum >>> SHIFT;
   assign sat_v = sat_signed(s1_r, OUT_W);
   assign clip  = s1_vld && (sat_v != s1_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         s1_vld      <= 1'b0;
         s1_r        <= '0;
         s2_vld      <= 1'b0;
         s2_data     <= '0;
         sat_sticky  <= 1'b0;
         drop_sticky <= 1'b0;
      end else begin
         if (din_vld) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end
         s1_vld <= keep;
         if (keep) begin
            s1_r <= r;
         end
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_data <= sat_v[OUT_W-1:0];
         end
         // A set event in the clearing cycle wins over clr.
         sat_sticky  <= (sat_sticky && !clr) || clip;
         drop_sticky <= (drop_sticky && !clr) || fifo_drop;
      end
   end

   fir_sync_fifo #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s2_vld),
      .wdata (s2_data),
      .pop   (dout_rdy),
      .head  (fifo_head),
      .level (level),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   assign dout     = fifo_head;
   assign dout_vld = !fifo_empty;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: three instances cover DEC=1, DEC=4/PHASE=0 and DEC=4/PHASE=3.
module tb_fir_out_requant;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [29:0] din = '0;
   logic               din_vld = 1'b0;
   logic               clr = 1'b0;
   logic               dout_rdy = 1'b0;

   logic signed [15:0] dout_a, dout_b, dout_c;
   logic               dout_vld_a, dout_vld_b, dout_vld_c;
   logic [2:0]         level_a, level_b, level_c;
   logic               sat_a, sat_b, sat_c;
   logic               drop_a, drop_b, drop_c;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   fir_out_requant #(.DEC(1), .PHASE(0)) u_d1 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
      .dout(dout_a), .dout_vld(dout_vld_a), .dout_rdy(dout_rdy), .level(level_a),
      .sat_sticky(sat_a), .drop_sticky(drop_a)
   );

   fir_out_requant #(.DEC(4), .PHASE(0)) u_d4p0 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
      .dout(dout_b), .dout_vld(dout_vld_b), .dout_rdy(dout_rdy), .level(level_b),
      .sat_sticky(sat_b), .drop_sticky(drop_b)
   );

   fir_out_requant #(.DEC(4), .PHASE(3)) u_d4p3 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
      .dout(dout_c), .dout_vld(dout_vld_c), .dout_rdy(dout_rdy), .level(level_c),
      .sat_sticky(sat_c), .drop_sticky(drop_c)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      din      = '0;
      din_vld  = 1'b0;
      clr      = 1'b0;
      dout_rdy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      vec_cnt++;
      if ({dout_vld_a, dout_a, level_a, sat_a, drop_a} !== 22'd0) begin
         err_cnt++;
         $display("FAIL reset_d1: got %h expected 0", {dout_vld_a, dout_a, level_a, sat_a, drop_a});
      end
      vec_cnt++;
      if ({dout_vld_b, dout_b, level_b, sat_b, drop_b} !== 22'd0) begin
         err_cnt++;
         $display("FAIL reset_d4p0: got %h expected 0", {dout_vld_b, dout_b, level_b, sat_b, drop_b});
      end
      vec_cnt++;
      if ({dout_vld_c, dout_c, level_c, sat_c, drop_c} !== 22'd0) begin
         err_cnt++;
         $display("FAIL reset_d4p3: got %h expected 0", {dout_vld_c, dout_c, level_c, sat_c, drop_c});
      end
   endtask

   task automatic test_rounding();
      int vin[4];
      int vexp[4];
      vin  = '{122880, -122880, 8191, 8192};
      vexp = '{8, -7, 0, 1};
      apply_reset();
      dout_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din     = 30'(vin[i]);
         din_vld = 1'b1;
         tick();
         din_vld = 1'b0;
         tick();
         vec_cnt++;
         if (dout_vld_a !== 1'b0) begin
            err_cnt++;
            $display("FAIL round_latency[%0d]: dout_vld got %b expected 0 after 2 edges", i, dout_vld_a);
         end
         tick();
         vec_cnt++;
         if (dout_vld_a !== 1'b1 || dout_a !== 16'(vexp[i])) begin
            err_cnt++;
            $display("FAIL round[%0d]: din %0d got vld %b dout %0d expected vld 1 dout %0d",
                     i, vin[i], dout_vld_a, dout_a, vexp[i]);
         end
         tick();
      end
      vec_cnt++;
      if (sat_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL round_sat_flag: got %b expected 0", sat_a);
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      dout_rdy = 1'b1;
      din      = 30'sd536862720;
      din_vld  = 1'b1;
      tick();
      din_vld = 1'b0;
      tick();
      tick();
      vec_cnt++;
      if (dout_vld_a !== 1'b1 || dout_a !== 16'sd32767 || sat_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL sat_pos: got vld %b dout %0d sat %b expected 1 32767 1", dout_vld_a, dout_a, sat_a);
      end
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      vec_cnt++;
      if (sat_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL sat_clr: got %b expected 0", sat_a);
      end
      din     = -30'sd536870912;
      din_vld = 1'b1;
      tick();
      din_vld = 1'b0;
      tick();
      tick();
      vec_cnt++;
      if (dout_vld_a !== 1'b1 || dout_a !== -16'sd32768 || sat_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL sat_neg: got vld %b dout %0d sat %b expected 1 -32768 0", dout_vld_a, dout_a, sat_a);
      end
      tick();
      // clr held in the same cycle the clip registers: the set must win
      din     = 30'sd536862720;
      din_vld = 1'b1;
      tick();
      din_vld = 1'b0;
      clr     = 1'b1;
      tick();
      clr = 1'b0;
      vec_cnt++;
      if (sat_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL sat_set_wins: got %b expected 1", sat_a);
      end
      tick();
      tick();
   endtask

   task automatic test_decimation();
      logic [15:0] exp_b[$];
      logic [15:0] exp_c[$];
      logic [15:0] e;
      int k;
      for (int i = 0; i <= 12; i += 4) exp_b.push_back(16'(i));
      for (int i = 3; i <= 11; i += 4) exp_c.push_back(16'(i));
      apply_reset();
      dout_rdy = 1'b1;
      k = 0;
      for (int t = 0; t < 27; t++) begin
         if (dout_vld_b) begin
            vec_cnt++;
            if (exp_b.size() == 0) begin
               err_cnt++;
               $display("FAIL dec_p0_extra: got %0d expected no sample", dout_b);
            end else begin
               e = exp_b.pop_front();
               if (dout_b !== e) begin
                  err_cnt++;
                  $display("FAIL dec_p0: got %0d expected %0d", dout_b, e);
               end
            end
         end
         if (dout_vld_c) begin
            vec_cnt++;
            if (exp_c.size() == 0) begin
               err_cnt++;
               $display("FAIL dec_p3_extra: got %0d expected no sample", dout_c);
            end else begin
               e = exp_c.pop_front();
               if (dout_c !== e) begin
                  err_cnt++;
                  $display("FAIL dec_p3: got %0d expected %0d", dout_c, e);
               end
            end
         end
         // 8 valid samples, a 5-cycle gap carrying junk, 6 more samples, then idle
         if ((t < 8) || (t >= 13 && t < 19)) begin
            din     = 30'(k * 16384);
            din_vld = 1'b1;
            k++;
         end else begin
            din     = 30'(999 * 16384);
            din_vld = 1'b0;
         end
         tick();
      end
      vec_cnt++;
      if (exp_b.size() != 0 || exp_c.size() != 0) begin
         err_cnt++;
         $display("FAIL dec_missing: got %0d/%0d samples left unseen expected 0/0", exp_b.size(), exp_c.size());
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      dout_rdy = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         din     = 30'(v * 16384);
         din_vld = 1'b1;
         tick();
      end
      din_vld = 1'b0;
      repeat (4) tick();
      vec_cnt++;
      if (level_a !== 3'd4 || drop_a !== 1'b1 || dout_vld_a !== 1'b1 || dout_a !== 16'sd1) begin
         err_cnt++;
         $display("FAIL ovf_full: got level %0d drop %b vld %b dout %0d expected 4 1 1 1",
                  level_a, drop_a, dout_vld_a, dout_a);
      end
      dout_rdy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         vec_cnt++;
         if (dout_vld_a !== 1'b1 || dout_a !== 16'(i)) begin
            err_cnt++;
            $display("FAIL ovf_drain[%0d]: got vld %b dout %0d expected 1 %0d", i, dout_vld_a, dout_a, i);
         end
         tick();
      end
      vec_cnt++;
      if (dout_vld_a !== 1'b0 || level_a !== 3'd0) begin
         err_cnt++;
         $display("FAIL ovf_empty: got vld %b level %0d expected 0 0", dout_vld_a, level_a);
      end
      dout_rdy = 1'b0;
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      dout_rdy = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         din     = 30'(v * 16384);
         din_vld = 1'b1;
         tick();
      end
      din_vld = 1'b0;
      tick();
      vec_cnt++;
      if (level_a !== 3'd4) begin
         err_cnt++;
         $display("FAIL fpp_prefill: got level %0d expected 4", level_a);
      end
      // pop exactly on the edge the fifth sample is pushed
      dout_rdy = 1'b1;
      tick();
      dout_rdy = 1'b0;
      vec_cnt++;
      if (level_a !== 3'd4 || drop_a !== 1'b0 || dout_a !== 16'sd2) begin
         err_cnt++;
         $display("FAIL fpp_swap: got level %0d drop %b dout %0d expected 4 0 2", level_a, drop_a, dout_a);
      end
      dout_rdy = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         vec_cnt++;
         if (dout_vld_a !== 1'b1 || dout_a !== 16'(i)) begin
            err_cnt++;
            $display("FAIL fpp_drain[%0d]: got vld %b dout %0d expected 1 %0d", i, dout_vld_a, dout_a, i);
         end
         tick();
      end
      vec_cnt++;
      if (dout_vld_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL fpp_empty: got vld %b expected 0", dout_vld_a);
      end
      dout_rdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      dout_rdy = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         din     = (v == 1) ? 30'sd536862720 : 30'(v * 16384);
         din_vld = 1'b1;
         tick();
      end
      din_vld = 1'b0;
      vec_cnt++;
      if (level_a !== 3'd3 || sat_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL rstmid_pre: got level %0d sat %b expected 3 1", level_a, sat_a);
      end
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({dout_vld_a, level_a, sat_a, drop_a, dout_vld_b, level_b, dout_vld_c, level_c} !== 14'd0) begin
         err_cnt++;
         $display("FAIL rstmid_async: got %h expected 0",
                  {dout_vld_a, level_a, sat_a, drop_a, dout_vld_b, level_b, dout_vld_c, level_c});
      end
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      vec_cnt++;
      if (dout_vld_a !== 1'b0 || level_a !== 3'd0) begin
         err_cnt++;
         $display("FAIL rstmid_flush: got vld %b level %0d expected 0 0", dout_vld_a, level_a);
      end
      din     = 30'(7 * 16384);
      din_vld = 1'b1;
      tick();
      din = 30'(9 * 16384);
      tick();
      din_vld = 1'b0;
      tick();
      vec_cnt++;
      if (dout_vld_b !== 1'b1 || dout_b !== 16'sd7 || dout_vld_c !== 1'b0) begin
         err_cnt++;
         $display("FAIL rstmid_phase: got p0 vld %b dout %0d p3 vld %b expected 1 7 0",
                  dout_vld_b, dout_b, dout_vld_c);
      end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_saturation();
      test_decimation();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
